// File: rtl/zap_wb_arbiter_if.sv
// Port bundle for zap_wb_arbiter: two Wishbone master ports plus the shared downstream bus.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface zap_wb_arbiter_if;

   // Master-side request ports (port 0 = data, port 1 = instruction)
   logic [1:0]  i_m_cyc;
   logic [1:0]  i_m_stb;
   logic [1:0]  i_m_we;
   logic [7:0]  i_m_sel;
   logic [5:0]  i_m_cti;
   logic [63:0] i_m_adr;
   logic [63:0] i_m_dat;
   logic [31:0] o_m_dat;
   logic [1:0]  o_m_ack;

   // Shared bus toward the store-FIFO bridge
   logic        o_wb_cyc;
   logic        o_wb_stb;
   logic        o_wb_we;
   logic [3:0]  o_wb_sel;
   logic [2:0]  o_wb_cti;
   logic [31:0] o_wb_adr;
   logic [31:0] o_wb_dat;
   logic [31:0] i_wb_dat;
   logic        i_wb_ack;

   logic [1:0]  o_gnt;

   modport slave (
      input  i_m_cyc, i_m_stb, i_m_we, i_m_sel, i_m_cti, i_m_adr, i_m_dat,
      output o_m_dat, o_m_ack,
      output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_cti, o_wb_adr, o_wb_dat,
      input  i_wb_dat, i_wb_ack,
      output o_gnt
   );

   modport master (
      output i_m_cyc, i_m_stb, i_m_we, i_m_sel, i_m_cti, i_m_adr, i_m_dat,
      input  o_m_dat, o_m_ack,
      input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_cti, o_wb_adr, o_wb_dat,
      output i_wb_dat, i_wb_ack,
      input  o_gnt
   );

endinterface

// File: rtl/zap_wb_arbiter.sv
// Two-port Wishbone arbiter with a programmable idle gap between grants.
// Define ZAP_WB_ARB_RR_EN for round-robin tie breaking; otherwise port 0 always wins ties.
module zap_wb_arbiter #(
   parameter int unsigned HANDOFF_GAP = 1
) (
   input  logic            i_clk,
   input  logic            i_reset,
   zap_wb_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GNT0,
      S_GNT1,
      S_GAP
   } state_t;

   localparam logic [3:0] GAP_LOAD = (HANDOFF_GAP > 0) ? 4'(HANDOFF_GAP - 1) : 4'd0;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [1:0] r_gnt;
   logic [1:0] w_gnt_nxt;
   logic [3:0] r_gap_cnt;
   logic [3:0] w_gap_cnt_nxt;
   logic       w_pick1;
   logic       w_active;
   logic       w_port;

`ifdef ZAP_WB_ARB_RR_EN
   logic r_rr_ptr;

   // A tie goes to the port the pointer does not name; the pointer tracks the last winner.
   assign w_pick1 = bus.i_m_cyc[1] & (~bus.i_m_cyc[0] | ~r_rr_ptr);

   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_rr_ptr <= 1'b1;
      else if ((r_state == S_IDLE) && (bus.i_m_cyc != 2'b00))
         r_rr_ptr <= w_pick1;
   end
`else
   assign w_pick1 = bus.i_m_cyc[1] & ~bus.i_m_cyc[0];
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_gnt     <= 2'b00;
         r_gap_cnt <= 4'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_gap_cnt <= w_gap_cnt_nxt;
      end
   end

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_gnt_nxt     = r_gnt;
      w_gap_cnt_nxt = r_gap_cnt;
      case (r_state)
         S_IDLE: begin
            if (bus.i_m_cyc != 2'b00) begin
               w_state_nxt = w_pick1 ? S_GNT1 : S_GNT0;
               w_gnt_nxt   = w_pick1 ? 2'b10 : 2'b01;
            end
         end
         S_GNT0, S_GNT1: begin
            // The owner keeps the bus until it drops CYC; there is no preemption.
            if (!bus.i_m_cyc[r_state == S_GNT1]) begin
               w_gnt_nxt = 2'b00;
               if (HANDOFF_GAP > 0) begin
                  w_state_nxt   = S_GAP;
                  w_gap_cnt_nxt = GAP_LOAD;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (r_gap_cnt == 4'd0)
               w_state_nxt = S_IDLE;
            else
               w_gap_cnt_nxt = r_gap_cnt - 4'd1;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = 2'b00;
         end
      endcase
   end

   assign w_active = (r_state == S_GNT0) || (r_state == S_GNT1);
   assign w_port   = (r_state == S_GNT1);

   always_comb begin
      bus.o_wb_cyc = 1'b0;
      bus.o_wb_stb = 1'b0;
      bus.o_wb_we  = 1'b0;
      bus.o_wb_sel = 4'h0;
      bus.o_wb_cti = 3'b000;
      bus.o_wb_adr = 32'h0;
      bus.o_wb_dat = 32'h0;
      bus.o_m_ack  = 2'b00;
      if (w_active) begin
         bus.o_wb_cyc = bus.i_m_cyc[w_port];
         bus.o_wb_stb = bus.i_m_stb[w_port] & bus.i_m_cyc[w_port];
         bus.o_wb_we  = bus.i_m_we[w_port];
         bus.o_wb_sel = w_port ? bus.i_m_sel[7:4]   : bus.i_m_sel[3:0];
         bus.o_wb_cti = w_port ? bus.i_m_cti[5:3]   : bus.i_m_cti[2:0];
         bus.o_wb_adr = w_port ? bus.i_m_adr[63:32] : bus.i_m_adr[31:0];
         bus.o_wb_dat = w_port ? bus.i_m_dat[63:32] : bus.i_m_dat[31:0];
         bus.o_m_ack[w_port] = bus.i_wb_ack;
      end
   end

   assign bus.o_m_dat = bus.i_wb_dat;
   assign bus.o_gnt   = r_gnt;

endmodule
